// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG_W-bit segment per stage, NSEG-cycle latency.
// A valid result not taken downstream freezes every stage and drops ready_o.
module pipelined_add_sub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam int NSEG = WIDTH / SEG_W;

  if (SEG_W < 1 || WIDTH % SEG_W != 0) begin : g_bad_width
    $error("pipelined_add_sub: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
  end

  logic stall;

  assign stall   = valid_o & ~ready_i;
  assign ready_o = ~stall;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Stage k consumes the lowest remaining operand segment and appends it to the partial sum.
    localparam int UPW = WIDTH - k * SEG_W;
    localparam int DNW = (k + 1) * SEG_W;

    logic [UPW-1:0] a_up;
    logic [UPW-1:0] b_up;
    logic           cin;
    logic           sub_in;
    logic           sa_in;
    logic           sb_in;
    logic           vld_in;
    logic [SEG_W:0] seg;
    logic [DNW-1:0] sum_d;
    logic [DNW-1:0] sum_q;
    logic           vld_q;

    if (k == 0) begin : g_in
      assign a_up   = a_i;
      assign b_up   = b_i ^ {WIDTH{sub_i}};
      assign cin    = sub_i;
      assign sub_in = sub_i;
      assign sa_in  = a_i[WIDTH-1];
      assign sb_in  = b_i[WIDTH-1];
      assign vld_in = valid_i;
      assign sum_d  = seg[SEG_W-1:0];
    end else begin : g_in
      assign a_up   = g_stage[k-1].g_fwd.a_q;
      assign b_up   = g_stage[k-1].g_fwd.b_q;
      assign cin    = g_stage[k-1].g_fwd.carry_q;
      assign sub_in = g_stage[k-1].g_fwd.sub_q;
      assign sa_in  = g_stage[k-1].g_fwd.sa_q;
      assign sb_in  = g_stage[k-1].g_fwd.sb_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign sum_d  = {seg[SEG_W-1:0], g_stage[k-1].sum_q};
    end

    assign seg = {1'b0, a_up[SEG_W-1:0]} + {1'b0, b_up[SEG_W-1:0]} + {{SEG_W{1'b0}}, cin};

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        sum_q <= '0;
      end else if (!stall) begin
        vld_q <= vld_in;
        sum_q <= sum_d;
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [UPW-SEG_W-1:0] a_q;
      logic [UPW-SEG_W-1:0] b_q;
      logic                 carry_q;
      logic                 sub_q;
      logic                 sa_q;
      logic                 sb_q;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          a_q     <= '0;
          b_q     <= '0;
          carry_q <= 1'b0;
          sub_q   <= 1'b0;
          sa_q    <= 1'b0;
          sb_q    <= 1'b0;
        end else if (!stall) begin
          a_q     <= a_up[UPW-1:SEG_W];
          b_q     <= b_up[UPW-1:SEG_W];
          carry_q <= seg[SEG_W];
          sub_q   <= sub_in;
          sa_q    <= sa_in;
          sb_q    <= sb_in;
        end
      end
    end else begin : g_out
      logic cout_q;
      logic ovf_q;
      logic zero_q;
      logic neg_q;
      logic rsign;
      logic ovf_d;

      // Overflow uses the original B sign, so subtract checks for differing operand signs.
      assign rsign = sum_d[WIDTH-1];
      assign ovf_d = sub_in ? ((sa_in ^ sb_in) & (rsign ^ sa_in))
                            : (~(sa_in ^ sb_in) & (rsign ^ sa_in));

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (!stall) begin
          cout_q <= seg[SEG_W] ^ sub_in;
          ovf_q  <= ovf_d;
          zero_q <= ~|sum_d;
          neg_q  <= rsign;
        end
      end
    end
  end

  assign valid_o  = g_stage[NSEG-1].vld_q;
  assign result_o = g_stage[NSEG-1].sum_q;
  assign cout_o   = g_stage[NSEG-1].g_out.cout_q;
  assign ovf_o    = g_stage[NSEG-1].g_out.ovf_q;
  assign zero_o   = g_stage[NSEG-1].g_out.zero_q;
  assign neg_o    = g_stage[NSEG-1].g_out.neg_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed corner cases plus random streams against an arithmetic model.
module tb_pipelined_add_sub;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int LAT   = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;
  logic             neg_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } exp_t;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .sub_i    (sub_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .cout_o   (cout_o),
    .ovf_o    (ovf_o),
    .zero_o   (zero_o),
    .neg_o    (neg_o)
  );

  // Reference: true integer arithmetic, then wrap and classify.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      st;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      u   = {1'b0, a} - {1'b0, b};
      e.c = (a < b);
      st  = sa - sb;
    end else begin
      u   = {1'b0, a} + {1'b0, b};
      e.c = u[32];
      st  = sa + sb;
    end
    e.res = u[31:0];
    e.o   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    e.z   = (e.res == 32'd0);
    e.n   = e.res[31];
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t g;
    g.res = result_o;
    g.c   = cout_o;
    g.o   = ovf_o;
    g.z   = zero_o;
    g.n   = neg_o;
    return g;
  endfunction

  // Issues one op into an empty pipeline and returns its latency and outputs (lat = -1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output exp_t got);
    a_i = a; b_i = b; sub_i = s; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid_o) lat = -1;
    got = observe();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0; sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++;
    if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    checks++;
    if ({cout_o, ovf_o, zero_o, neg_o} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cout_o, ovf_o, zero_o, neg_o}); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_boundary();
    int lat; exp_t g;
    run_op(32'h000000FF, 32'h00000001, 1'b0, lat, g);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL carry_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (g.res !== 32'h00000100) begin errors++; $display("FAIL carry_result: got %h expected 00000100", g.res); end
    checks++;
    if ({g.c, g.o, g.z, g.n} !== 4'b0000)
      begin errors++; $display("FAIL carry_flags: got %b expected 0000", {g.c, g.o, g.z, g.n}); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL carry_drain: got valid %b expected 0", valid_o); end
  endtask

  task automatic test_borrow();
    int lat; exp_t g;
    run_op(32'd5, 32'd7, 1'b1, lat, g);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL borrow_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (g.res !== 32'hFFFFFFFE) begin errors++; $display("FAIL borrow_result: got %h expected fffffffe", g.res); end
    checks++;
    if ({g.c, g.o, g.z, g.n} !== 4'b1001)
      begin errors++; $display("FAIL borrow_flags: got %b expected 1001", {g.c, g.o, g.z, g.n}); end
  endtask

  task automatic test_overflow();
    int lat; exp_t g;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, g);
    checks++;
    if (g.res !== 32'h80000000) begin errors++; $display("FAIL ovf_add_result: got %h expected 80000000", g.res); end
    checks++;
    if ({g.c, g.o, g.z, g.n} !== 4'b0101)
      begin errors++; $display("FAIL ovf_add_flags: got %b expected 0101", {g.c, g.o, g.z, g.n}); end
    run_op(32'h80000000, 32'h00000001, 1'b1, lat, g);
    checks++;
    if (g.res !== 32'h7FFFFFFF) begin errors++; $display("FAIL ovf_sub_result: got %h expected 7fffffff", g.res); end
    checks++;
    if ({g.c, g.o, g.z, g.n} !== 4'b0100)
      begin errors++; $display("FAIL ovf_sub_flags: got %b expected 0100", {g.c, g.o, g.z, g.n}); end
  endtask

  task automatic test_full_ripple();
    int lat; exp_t g;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, g);
    checks++;
    if (g.res !== 32'd0) begin errors++; $display("FAIL ripple_result: got %h expected 0", g.res); end
    checks++;
    if ({g.c, g.o, g.z, g.n} !== 4'b1010)
      begin errors++; $display("FAIL ripple_flags: got %b expected 1010", {g.c, g.o, g.z, g.n}); end
    run_op(32'h00001234, 32'h00001234, 1'b1, lat, g);
    checks++;
    if (g.res !== 32'd0) begin errors++; $display("FAIL self_sub_result: got %h expected 0", g.res); end
    checks++;
    if ({g.c, g.o, g.z, g.n} !== 4'b0010)
      begin errors++; $display("FAIL self_sub_flags: got %b expected 0010", {g.c, g.o, g.z, g.n}); end
  endtask

  task automatic test_random_ops();
    int lat; exp_t g; exp_t e;
    logic [31:0] pick [4];
    logic [31:0] a; logic [31:0] b; logic s;
    for (int i = 0; i < 12; i++) begin
      pick[0] = $urandom; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000; pick[3] = 32'h7FFFFFFF;
      a = pick[$urandom_range(0, 3)];
      pick[0] = $urandom;
      b = pick[$urandom_range(0, 3)];
      s = 1'($urandom_range(0, 1));
      e = ref_model(a, b, s);
      run_op(a, b, s, lat, g);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      checks++;
      if (g !== e) begin errors++; $display("FAIL rand_op[%0d]: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_backpressure();
    exp_t        q[$];
    exp_t        e;
    exp_t        cur;
    exp_t        snap;
    logic [31:0] ra [8];
    logic [31:0] rb [8];
    logic        rs [8];
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          stall_seen = 0;
    logic        prev_stall = 1'b0;
    logic        snap_v = 1'b0;
    logic        acc;
    snap = '0;
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rs[i] = 1'($urandom_range(0, 1));
    end
    while ((sent < 8 || got < 8) && cyc < 60) begin
      ready_i = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        valid_i = 1'b1; a_i = ra[sent]; b_i = rb[sent]; sub_i = rs[sent];
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
      cur = observe();
      checks++;
      if (ready_o !== !(valid_o && !ready_i))
        begin errors++; $display("FAIL bp_ready[cyc %0d]: got %b expected %b", cyc, ready_o, !(valid_o && !ready_i)); end
      if (prev_stall) begin
        checks++;
        if ({valid_o, cur} !== {snap_v, snap})
          begin errors++; $display("FAIL bp_hold[cyc %0d]: got %h expected %h", cyc, {valid_o, cur}, {snap_v, snap}); end
      end
      if (!ready_o) stall_seen++;
      if (valid_o && ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_duplicate[cyc %0d]: got %h expected no output", cyc, cur);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin errors++; $display("FAIL bp_result[%0d]: got %h expected %h", got, cur, e); end
        end
        got++;
      end
      acc        = valid_i && ready_o;
      prev_stall = valid_o && !ready_i;
      snap       = cur;
      snap_v     = valid_o;
      @(posedge clk);
      if (acc) begin
        q.push_back(ref_model(a_i, b_i, sub_i));
        sent++;
      end
      #1;
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    checks++;
    if (got !== 8) begin errors++; $display("FAIL bp_count: got %0d outputs expected 8", got); end
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL bp_lost: got %0d pending expected 0", q.size()); end
    checks++;
    if (stall_seen !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen); end
  endtask

  task automatic test_reset_inflight();
    int lat; exp_t g; exp_t e;
    int seen = 0;
    logic [31:0] a; logic [31:0] b;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; a_i = $urandom; b_i = $urandom; sub_i = 1'(i & 1);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    rst_ni  = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_fly_valid: got %b expected 0", valid_o); end
    checks++;
    if ({result_o, cout_o, ovf_o, zero_o, neg_o} !== 36'd0)
      begin errors++; $display("FAIL rst_fly_outputs: got %h expected 0", {result_o, cout_o, ovf_o, zero_o, neg_o}); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_fly_ready: got %b expected 1", ready_o); end
    for (int i = 0; i < 8; i++) begin
      if (valid_o) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_fly_emitted: got %0d outputs expected 0", seen); end
    a = $urandom; b = $urandom;
    e = ref_model(a, b, 1'b0);
    run_op(a, b, 1'b0, lat, g);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL rst_fly_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (g !== e) begin errors++; $display("FAIL rst_fly_result: got %h expected %h", g, e); end
  endtask

  initial begin
    test_reset();
    test_carry_boundary();
    test_borrow();
    test_overflow();
    test_full_ripple();
    test_random_ops();
    test_backpressure();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
